uart_result_tx: RTL and testbench

UART_RESULT_TX -- requirements
Module: uart_result_tx

---
 rtl/uart_result_tx_pkg.sv | 15 +
 rtl/uart_byte_serializer.sv | 95 +++++++++
 rtl/uart_result_tx.sv | 102 ++++++++++
 tb/tb_uart_result_tx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_result_tx_pkg.sv
// Shared types and constants for the UART result transmitter and its byte serializer.
package uart_result_tx_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_e;

   localparam logic [7:0] DEFAULT_HEADER   = 8'hA5;
   localparam int         FRAME_BYTES_BASE = 6;
   localparam int         FRAME_BYTES_CSUM = 7;

   // Checksum covers the five payload bytes; the header is deliberately left out.
   function automatic logic [7:0] frameChecksum(input logic [31:0] data, input logic [4:0] flags);
      return data[31:24] ^ data[23:16] ^ data[15:8] ^ data[7:0] ^ {3'b000, flags};
   endfunction

endpackage

// File: rtl/uart_byte_serializer.sv
// One 8N1 byte on a registered serial line, with a per-bit timer and a ready/valid input.
module uart_byte_serializer
   import uart_result_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10417
)
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_valid,
   input  logic [7:0] i_byte,
   output logic       o_ready,
   output logic       o_tx,
   output logic       o_busy
);

   localparam int            TW   = $clog2(CLKS_PER_BIT + 1);
   localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);

   txState_e      r_state;
   logic [TW-1:0] r_timer;
   logic [2:0]    r_bitIdx;
   logic [7:0]    r_shift;
   logic          r_tx;
   logic          r_busy;
   logic          w_bitEnd;

   assign w_bitEnd = (r_timer == TMAX);
   // Ready in the last stop-bit cycle lets the next start bit follow with no gap.
   assign o_ready  = (r_state == IDLE) || ((r_state == STOP) && w_bitEnd);
   assign o_tx     = r_tx;
   assign o_busy   = r_busy;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= IDLE;
         r_timer  <= '0;
         r_bitIdx <= '0;
         r_shift  <= '0;
         r_tx     <= 1'b1;
         r_busy   <= 1'b0;
      end else begin
         if ((r_state == IDLE) || w_bitEnd)
            r_timer <= '0;
         else
            r_timer <= r_timer + TW'(1);

         case (r_state)
            IDLE: begin
               r_tx <= 1'b1;
               if (i_valid) begin
                  r_shift <= i_byte;
                  r_tx    <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= START;
               end
            end
            START: begin
               if (w_bitEnd) begin
                  r_tx     <= r_shift[0];
                  r_bitIdx <= '0;
                  r_state  <= DATA;
               end
            end
            DATA: begin
               if (w_bitEnd) begin
                  if (r_bitIdx == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= STOP;
                  end else begin
                     r_tx     <= r_shift[1];
                     r_shift  <= {1'b0, r_shift[7:1]};
                     r_bitIdx <= r_bitIdx + 3'd1;
                  end
               end
            end
            STOP: begin
               if (w_bitEnd) begin
                  if (i_valid) begin
                     r_shift <= i_byte;
                     r_tx    <= 1'b0;
                     r_state <= START;
                  end else begin
                     r_tx    <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_result_tx.sv
// Sends a result frame (header, four data bytes, flags byte) over 8N1 UART.
// Define UART_RESULT_TX_CHECKSUM_EN to append a seventh XOR checksum byte.
module uart_result_tx
   import uart_result_tx_pkg::*;
#(
   parameter int         CLKS_PER_BIT = 10417,
   parameter logic [7:0] HEADER       = DEFAULT_HEADER
)
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_send,
   input  logic [31:0] i_data,
   input  logic [4:0]  i_flags,
   output logic        o_tx,
   output logic        o_busy,
   output logic        o_done
);

`ifdef UART_RESULT_TX_CHECKSUM_EN
   localparam int FRAME_BYTES = FRAME_BYTES_CSUM;
`else
   localparam int FRAME_BYTES = FRAME_BYTES_BASE;
`endif
   localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

   logic [31:0] r_data;
   logic [4:0]  r_flags;
   logic [2:0]  r_byteIdx;
   logic        r_done;
   logic        w_serBusy;
   logic        w_ready;
   logic        w_valid;
   logic [2:0]  w_seqIdx;
   logic [7:0]  w_byte;

   // The header goes out straight from the request edge; later bytes are handed over at each stop-bit end.
   always_comb begin
      w_valid  = 1'b0;
      w_seqIdx = 3'd0;
      if (!w_serBusy) begin
         w_valid = i_send;
      end else if (w_ready && (r_byteIdx != LAST_IDX)) begin
         w_valid  = 1'b1;
         w_seqIdx = r_byteIdx + 3'd1;
      end
   end

   always_comb begin
      w_byte = HEADER;
      case (w_seqIdx)
         3'd1:    w_byte = r_data[31:24];
         3'd2:    w_byte = r_data[23:16];
         3'd3:    w_byte = r_data[15:8];
         3'd4:    w_byte = r_data[7:0];
         3'd5:    w_byte = {3'b000, r_flags};
`ifdef UART_RESULT_TX_CHECKSUM_EN
         3'd6:    w_byte = frameChecksum(r_data, r_flags);
`endif
         default: w_byte = HEADER;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_data    <= '0;
         r_flags   <= '0;
         r_byteIdx <= '0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (!w_serBusy) begin
            if (i_send) begin
               r_data    <= i_data;
               r_flags   <= i_flags;
               r_byteIdx <= '0;
            end
         end else if (w_ready) begin
            if (r_byteIdx == LAST_IDX)
               r_done <= 1'b1;
            else
               r_byteIdx <= r_byteIdx + 3'd1;
         end
      end
   end

   uart_byte_serializer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_serializer (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_valid (w_valid),
      .i_byte  (w_byte),
      .o_ready (w_ready),
      .o_tx    (o_tx),
      .o_busy  (w_serBusy)
   );

   assign o_busy = w_serBusy;
   assign o_done = r_done;

endmodule

// File: tb/tb_uart_result_tx.sv
// Scoreboard bench for uart_result_tx: a line decoder pops expected bytes queued at each request.
// Honours UART_RESULT_TX_CHECKSUM_EN for the expected frame contents and length.
module tb_uart_result_tx;

   localparam int         CPB       = 4;
   localparam logic [7:0] TB_HEADER = 8'hA5;
`ifdef UART_RESULT_TX_CHECKSUM_EN
   localparam int FRAME_CYC = 70 * CPB;
`else
   localparam int FRAME_CYC = 60 * CPB;
`endif
   localparam int LIMIT = 400;

   logic        clk;
   logic        rstN;
   logic        send;
   logic [31:0] data;
   logic [4:0]  flags;
   logic        oTx;
   logic        oBusy;
   logic        oDone;

   logic [7:0] expQ[$];
   int         checkCount = 0;
   int         errorCount = 0;
   int         doneCount  = 0;

   uart_result_tx #(
      .CLKS_PER_BIT (CPB),
      .HEADER       (TB_HEADER)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rstN),
      .i_send  (send),
      .i_data  (data),
      .i_flags (flags),
      .o_tx    (oTx),
      .o_busy  (oBusy),
      .o_done  (oDone)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drives one request cycle from a negedge and queues the bytes the frame must carry.
   task automatic applyStimulus(input logic [31:0] d, input logic [4:0] f);
      logic [7:0] csum;
      send  = 1'b1;
      data  = d;
      flags = f;
      expQ.push_back(TB_HEADER);
      expQ.push_back(d[31:24]);
      expQ.push_back(d[23:16]);
      expQ.push_back(d[15:8]);
      expQ.push_back(d[7:0]);
      expQ.push_back({3'b000, f});
      csum = d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0] ^ {3'b000, f};
`ifdef UART_RESULT_TX_CHECKSUM_EN
      expQ.push_back(csum);
`endif
      @(negedge clk);
      send = 1'b0;
   endtask

   // Entered on cycle 0 of a frame; counts busy cycles, flags edges off the bit grid, optionally injects a stray request.
   task automatic measureFrame(input int injectAt, output int busyCyc, output int badEdges, output logic doneOk);
      logic prevTx;
      busyCyc  = 0;
      badEdges = 0;
      prevTx   = 1'b1;
      while ((oBusy === 1'b1) && (busyCyc < LIMIT)) begin
         if ((oTx !== prevTx) && ((busyCyc % CPB) != 0)) badEdges++;
         prevTx = oTx;
         if (busyCyc == injectAt) begin
            send  = 1'b1;
            data  = 32'hDEAD_BEEF;
            flags = 5'h0A;
         end else begin
            send = 1'b0;
         end
         busyCyc++;
         @(negedge clk);
      end
      send   = 1'b0;
      doneOk = (oDone === 1'b1) && (oTx === 1'b1);
   endtask

   task automatic checkFrame(input string tag, input int busyCyc, input int badEdges, input logic doneOk);
      checkOutput({tag, "_frameLen"}, 32'(busyCyc), 32'(FRAME_CYC));
      checkOutput({tag, "_edgeAlign"}, 32'(badEdges), 32'd0);
      checkOutput({tag, "_doneAtEnd"}, 32'(doneOk), 32'd1);
      checkOutput({tag, "_queueDrained"}, 32'(expQ.size()), 32'd0);
   endtask

   // Line decoder: bit k of a byte is sampled mid-bit, CPB cycles per bit from the start-bit edge.
   initial begin
      int         pos;
      logic       inByte;
      logic [7:0] rx;
      logic [7:0] expByte;
      inByte = 1'b0;
      pos    = 0;
      rx     = '0;
      forever begin
         @(negedge clk);
         if (rstN !== 1'b1) begin
            inByte = 1'b0;
            pos    = 0;
         end else begin
            if (oDone === 1'b1) doneCount++;
            if (!inByte) begin
               if (oTx === 1'b0) begin
                  inByte = 1'b1;
                  pos    = 0;
               end
            end else begin
               pos++;
               if (pos == CPB / 2) begin
                  checkOutput("startBit", 32'(oTx), 32'd0);
               end else if ((pos > CPB) && (pos < 9 * CPB) && ((pos % CPB) == CPB / 2)) begin
                  rx = {oTx, rx[7:1]};
               end else if (pos == 9 * CPB + CPB / 2) begin
                  checkOutput("stopBit", 32'(oTx), 32'd1);
                  checkOutput("byteExpected", 32'(expQ.size() > 0), 32'd1);
                  if (expQ.size() > 0) begin
                     expByte = expQ.pop_front();
                     checkOutput("rxByte", 32'(rx), 32'(expByte));
                  end
                  inByte = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int   busyCyc;
      int   badEdges;
      logic doneOk;
      int   doneSnap;

      rstN  = 1'b0;
      send  = 1'b0;
      data  = '0;
      flags = '0;
      repeat (3) @(negedge clk);
      checkOutput("rstTx", 32'(oTx), 32'd1);
      checkOutput("rstBusy", 32'(oBusy), 32'd0);
      checkOutput("rstDone", 32'(oDone), 32'd0);
      rstN = 1'b1;

      $display("[TB] idle after reset release");
      for (int i = 0; i < 5; i++) begin
         repeat (8) @(negedge clk);
         checkOutput("idleTx", 32'(oTx), 32'd1);
         checkOutput("idleBusy", 32'(oBusy), 32'd0);
         checkOutput("idleDone", 32'(oDone), 32'd0);
      end

      $display("[TB] basic frame");
      applyStimulus(32'h1234_ABCD, 5'b10011);
      checkOutput("basicStartLow", 32'(oTx), 32'd0);
      measureFrame(-1, busyCyc, badEdges, doneOk);
      checkFrame("basic", busyCyc, badEdges, doneOk);
      checkOutput("basicBusyLow", 32'(oBusy), 32'd0);
      repeat (5) @(negedge clk);
      checkOutput("basicDonePulse", 32'(oDone), 32'd0);

      $display("[TB] request during frame is ignored");
      applyStimulus(32'hCAFE_0123, 5'h05);
      measureFrame(10, busyCyc, badEdges, doneOk);
      checkFrame("ignore", busyCyc, badEdges, doneOk);
      repeat (60) @(negedge clk);
      checkOutput("ignoreNoSecondFrame", 32'(oBusy), 32'd0);

      $display("[TB] back-to-back frames");
      applyStimulus(32'h0F1E_2D3C, 5'h11);
      measureFrame(-1, busyCyc, badEdges, doneOk);
      checkFrame("b2bFirst", busyCyc, badEdges, doneOk);
      checkOutput("b2bLowCycle", 32'(oBusy), 32'd0);
      applyStimulus(32'h8877_6655, 5'h0C);
      checkOutput("b2bBusyLowOne", 32'(oBusy), 32'd1);
      checkOutput("b2bStartNoGap", 32'(oTx), 32'd0);
      measureFrame(-1, busyCyc, badEdges, doneOk);
      checkFrame("b2bSecond", busyCyc, badEdges, doneOk);
      repeat (5) @(negedge clk);

      $display("[TB] reset in the middle of a frame");
      applyStimulus(32'h5A5A_C3C3, 5'h1F);
      doneSnap = doneCount;
      repeat (95) @(negedge clk);
      checkOutput("abortBusyBefore", 32'(oBusy), 32'd1);
      #2 rstN = 1'b0;
      #1;
      checkOutput("abortTxAsync", 32'(oTx), 32'd1);
      checkOutput("abortBusyAsync", 32'(oBusy), 32'd0);
      checkOutput("abortDoneAsync", 32'(oDone), 32'd0);
      expQ.delete();
      repeat (4) @(negedge clk);
      rstN = 1'b1;
      repeat (20) @(negedge clk);
      checkOutput("abortNoDone", 32'(doneCount - doneSnap), 32'd0);
      checkOutput("abortIdleTx", 32'(oTx), 32'd1);
      applyStimulus(32'h2468_ACE0, 5'h07);
      measureFrame(-1, busyCyc, badEdges, doneOk);
      checkFrame("afterAbort", busyCyc, badEdges, doneOk);
      repeat (5) @(negedge clk);

      $display("[TB] all-ones data, zero flags, bit timing");
      applyStimulus(32'hFFFF_FFFF, 5'h00);
      measureFrame(-1, busyCyc, badEdges, doneOk);
      checkFrame("ones", busyCyc, badEdges, doneOk);
      repeat (10) @(negedge clk);
      checkOutput("finalIdleTx", 32'(oTx), 32'd1);
      checkOutput("finalQueue", 32'(expQ.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
